// File: rtl/egr_tuser_insert_pkg.sv
// Shared definitions for the egress tuser/tdest insertion stage:
// FSM state encoding and the port-width helpers for tid and tdest.
package egr_tuser_insert_pkg;

  // IDLE: no decision held, waiting on the egress filter.
  // PASS: decision held, packet beats are forwarded.
  typedef enum logic [0:0] {
    ST_IDLE = 1'b0,
    ST_PASS = 1'b1
  } state_e;

  // tid ports keep at least one bit even when the VM id width is zero.
  function automatic int tid_width(input int id_w);
    return (id_w > 1) ? id_w : 1;
  endfunction

  // tdest carries one extra bit above the VM id.
  function automatic int tdest_width(input int id_w);
    return id_w + 1;
  endfunction

endpackage

// File: rtl/egr_tuser_insert_skid_buf.sv
// Two-entry register slice: a main (output) register plus one skid entry.
// The upstream ready is meant to be registered from skid_free_next, so an
// accepted beat always has a free slot to land in. Order is preserved.
module nmu_axis_skid_buf #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             push,
  input  logic [WIDTH-1:0] push_data,
  output logic             out_valid,
  output logic [WIDTH-1:0] out_data,
  input  logic             out_ready,
  output logic             skid_free_next
);

  logic             main_valid_q, main_valid_d;
  logic [WIDTH-1:0] main_data_q, main_data_d;
  logic             skid_valid_q, skid_valid_d;
  logic [WIDTH-1:0] skid_data_q, skid_data_d;
  logic             pop_s;

  assign pop_s          = main_valid_q && out_ready;
  assign out_valid      = main_valid_q;
  assign out_data       = main_data_q;
  assign skid_free_next = !skid_valid_d;

  // Next-state of the two entries: refill main from skid first, then from input.
  always_comb begin
    main_valid_d = main_valid_q;
    main_data_d  = main_data_q;
    skid_valid_d = skid_valid_q;
    skid_data_d  = skid_data_q;
    if (skid_valid_q) begin
      if (pop_s) begin
        main_data_d  = skid_data_q;
        main_valid_d = 1'b1;
        skid_valid_d = 1'b0;
      end else begin
        skid_valid_d = 1'b1;
      end
    end else if (push) begin
      if (!main_valid_q || pop_s) begin
        main_data_d  = push_data;
        main_valid_d = 1'b1;
      end else begin
        skid_data_d  = push_data;
        skid_valid_d = 1'b1;
      end
    end else if (pop_s) begin
      main_valid_d = 1'b0;
    end else begin
      main_valid_d = main_valid_q;
    end
  end

  // Entry registers; everything clears on reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      main_valid_q <= 1'b0;
      main_data_q  <= {WIDTH{1'b0}};
      skid_valid_q <= 1'b0;
      skid_data_q  <= {WIDTH{1'b0}};
    end else begin
      main_valid_q <= main_valid_d;
      main_data_q  <= main_data_d;
      skid_valid_q <= skid_valid_d;
      skid_data_q  <= skid_data_d;
    end
  end

endmodule

// File: rtl/egr_tuser_insert.sv
// Egress tuser/tdest insertion: takes one filter decision per packet, stamps
// its drop flag onto tuser and its routing value onto tdest for every beat,
// holds the first beat's tid for the whole packet, and registers the result
// through a two-entry skid buffer.
module egr_tuser_insert
  import egr_tuser_insert_pkg::*;
#(
  parameter int AXIS_BUS_WIDTH = 64,
  parameter int AXIS_ID_WIDTH  = 4
) (
  input  logic                                  aclk,
  input  logic                                  aresetn,
  input  logic [AXIS_BUS_WIDTH-1:0]             axis_in_tdata,
  input  logic [tid_width(AXIS_ID_WIDTH)-1:0]   axis_in_tid,
  input  logic [AXIS_BUS_WIDTH/8-1:0]           axis_in_tkeep,
  input  logic                                  axis_in_tlast,
  input  logic                                  axis_in_tvalid,
  output logic                                  axis_in_tready,
  input  logic                                  dec_tuser,
  input  logic [tdest_width(AXIS_ID_WIDTH)-1:0] dec_tdest,
  input  logic                                  dec_valid,
  output logic                                  dec_ready,
  output logic [AXIS_BUS_WIDTH-1:0]             axis_out_tdata,
  output logic                                  axis_out_tuser,
  output logic [tid_width(AXIS_ID_WIDTH)-1:0]   axis_out_tid,
  output logic [tdest_width(AXIS_ID_WIDTH)-1:0] axis_out_tdest,
  output logic [AXIS_BUS_WIDTH/8-1:0]           axis_out_tkeep,
  output logic                                  axis_out_tlast,
  output logic                                  axis_out_tvalid,
  input  logic                                  axis_out_tready
);

  localparam int TID_W     = tid_width(AXIS_ID_WIDTH);
  localparam int TDEST_W   = tdest_width(AXIS_ID_WIDTH);
  localparam int KEEP_W    = AXIS_BUS_WIDTH / 8;
  localparam int PAYLOAD_W = AXIS_BUS_WIDTH + 1 + TID_W + TDEST_W + KEEP_W + 1;

  // PASS state doubles as "decision held".
  state_e               state_q, state_d;
  logic                 tuser_q, tuser_d;
  logic [TDEST_W-1:0]   tdest_q, tdest_d;
  logic [TID_W-1:0]     tid_q, tid_d;
  logic                 first_beat_q, first_beat_d;
  logic                 in_ready_q, in_ready_d;
  logic                 dec_ready_q, dec_ready_d;
  logic                 in_acc_s, dec_acc_s;
  logic [TID_W-1:0]     tid_sel_s;
  logic [PAYLOAD_W-1:0] payload_in_s, payload_out_s;
  logic                 skid_free_nxt_s;

  assign in_acc_s       = axis_in_tvalid && in_ready_q;
  assign dec_acc_s      = dec_valid && dec_ready_q;
  assign axis_in_tready = in_ready_q;
  assign dec_ready      = dec_ready_q;

  // Next state: take a decision in IDLE, return to IDLE after the tlast beat.
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: begin
        if (dec_acc_s) state_d = ST_PASS;
        else           state_d = ST_IDLE;
      end
      ST_PASS: begin
        if (in_acc_s && axis_in_tlast) state_d = ST_IDLE;
        else                           state_d = ST_PASS;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // Per-packet context: latched decision, first-beat tid capture.
  always_comb begin
    tuser_d      = tuser_q;
    tdest_d      = tdest_q;
    tid_d        = tid_q;
    first_beat_d = first_beat_q;
    if (state_q == ST_IDLE) begin
      if (dec_acc_s) begin
        tuser_d      = dec_tuser;
        tdest_d      = dec_tdest;
        first_beat_d = 1'b1;
      end else begin
        first_beat_d = first_beat_q;
      end
    end else if (in_acc_s && first_beat_q) begin
      tid_d        = axis_in_tid;
      first_beat_d = 1'b0;
    end else begin
      first_beat_d = first_beat_q;
    end
  end

  // Outputs: registered readies and the beat payload handed to the skid buffer.
  always_comb begin
    in_ready_d  = (state_d == ST_PASS) && skid_free_nxt_s;
    dec_ready_d = (state_d == ST_IDLE);
    if (first_beat_q) tid_sel_s = axis_in_tid;
    else              tid_sel_s = tid_q;
    payload_in_s = {axis_in_tdata, tuser_q, tid_sel_s, tdest_q, axis_in_tkeep, axis_in_tlast};
  end

  // Control and context registers.
  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      state_q      <= ST_IDLE;
      tuser_q      <= 1'b0;
      tdest_q      <= {TDEST_W{1'b0}};
      tid_q        <= {TID_W{1'b0}};
      first_beat_q <= 1'b1;
      in_ready_q   <= 1'b0;
      dec_ready_q  <= 1'b0;
    end else begin
      state_q      <= state_d;
      tuser_q      <= tuser_d;
      tdest_q      <= tdest_d;
      tid_q        <= tid_d;
      first_beat_q <= first_beat_d;
      in_ready_q   <= in_ready_d;
      dec_ready_q  <= dec_ready_d;
    end
  end

  nmu_axis_skid_buf #(
    .WIDTH(PAYLOAD_W)
  ) u_skid (
    .clk           (aclk),
    .rst_n         (aresetn),
    .push          (in_acc_s),
    .push_data     (payload_in_s),
    .out_valid     (axis_out_tvalid),
    .out_data      (payload_out_s),
    .out_ready     (axis_out_tready),
    .skid_free_next(skid_free_nxt_s)
  );

  assign {axis_out_tdata, axis_out_tuser, axis_out_tid, axis_out_tdest,
          axis_out_tkeep, axis_out_tlast} = payload_out_s;

endmodule

// File: tb/tb_egr_tuser_insert.sv
// Directed bench for egr_tuser_insert: decisions and beats driven from tasks,
// output beats captured on the falling edge and compared with hand-built
// expectations.
module tb_egr_tuser_insert;

  logic        aclk = 1'b0;
  logic        aresetn = 1'b0;
  logic [63:0] axis_in_tdata = 64'd0;
  logic [3:0]  axis_in_tid = 4'd0;
  logic [7:0]  axis_in_tkeep = 8'd0;
  logic        axis_in_tlast = 1'b0;
  logic        axis_in_tvalid = 1'b0;
  logic        axis_in_tready;
  logic        dec_tuser = 1'b0;
  logic [4:0]  dec_tdest = 5'd0;
  logic        dec_valid = 1'b0;
  logic        dec_ready;
  logic [63:0] axis_out_tdata;
  logic        axis_out_tuser;
  logic [3:0]  axis_out_tid;
  logic [4:0]  axis_out_tdest;
  logic [7:0]  axis_out_tkeep;
  logic        axis_out_tlast;
  logic        axis_out_tvalid;
  logic        axis_out_tready = 1'b1;

  int n_checks = 0;
  int n_fail = 0;
  int cyc = 0;
  logic [82:0] obs_q[$];
  logic [82:0] exp_q[$];

  egr_tuser_insert #(.AXIS_BUS_WIDTH(64), .AXIS_ID_WIDTH(4)) dut (
    .aclk(aclk), .aresetn(aresetn),
    .axis_in_tdata(axis_in_tdata), .axis_in_tid(axis_in_tid),
    .axis_in_tkeep(axis_in_tkeep), .axis_in_tlast(axis_in_tlast),
    .axis_in_tvalid(axis_in_tvalid), .axis_in_tready(axis_in_tready),
    .dec_tuser(dec_tuser), .dec_tdest(dec_tdest),
    .dec_valid(dec_valid), .dec_ready(dec_ready),
    .axis_out_tdata(axis_out_tdata), .axis_out_tuser(axis_out_tuser),
    .axis_out_tid(axis_out_tid), .axis_out_tdest(axis_out_tdest),
    .axis_out_tkeep(axis_out_tkeep), .axis_out_tlast(axis_out_tlast),
    .axis_out_tvalid(axis_out_tvalid), .axis_out_tready(axis_out_tready)
  );

  always #5 aclk = ~aclk;

  // Cycle counter used to time handshakes.
  always @(posedge aclk) cyc <= cyc + 1;

  // Capture every output handshake, sampled mid-cycle.
  always @(negedge aclk) begin
    if (aresetn && axis_out_tvalid && axis_out_tready)
      obs_q.push_back({axis_out_tdata, axis_out_tuser, axis_out_tid,
                       axis_out_tdest, axis_out_tkeep, axis_out_tlast});
  end

  function automatic logic [82:0] pk(input logic [63:0] d, input logic u,
                                     input logic [3:0] id, input logic [4:0] dst,
                                     input logic [7:0] k, input logic l);
    return {d, u, id, dst, k, l};
  endfunction

  task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge aclk);
    #1;
  endtask

  task automatic send_dec(input logic u, input logic [4:0] dst, output int acc);
    logic ok;
    ok = 1'b0;
    acc = -1;
    dec_tuser = u;
    dec_tdest = dst;
    dec_valid = 1'b1;
    for (int i = 0; i < 50; i++) begin
      @(negedge aclk);
      if (dec_ready) begin
        tick();
        acc = cyc;
        ok = 1'b1;
        break;
      end
    end
    dec_valid = 1'b0;
    check("dec_accepted", 128'(ok), 128'd1);
  endtask

  task automatic send_beat(input logic [63:0] d, input logic [3:0] id,
                           input logic [7:0] k, input logic l, output int acc);
    logic ok;
    ok = 1'b0;
    acc = -1;
    axis_in_tdata = d;
    axis_in_tid = id;
    axis_in_tkeep = k;
    axis_in_tlast = l;
    axis_in_tvalid = 1'b1;
    for (int i = 0; i < 50; i++) begin
      @(negedge aclk);
      if (axis_in_tready) begin
        tick();
        acc = cyc;
        ok = 1'b1;
        break;
      end
    end
    axis_in_tvalid = 1'b0;
    check("beat_accepted", 128'(ok), 128'd1);
  endtask

  task automatic drain(input string tag);
    for (int i = 0; i < 100 && obs_q.size() < exp_q.size(); i++) tick();
    tick();
    tick();
    check({tag, "_count"}, 128'(obs_q.size()), 128'(exp_q.size()));
    for (int i = 0; i < exp_q.size(); i++)
      if (i < obs_q.size())
        check($sformatf("%s_beat%0d", tag, i), 128'(obs_q[i]), 128'(exp_q[i]));
    obs_q.delete();
    exp_q.delete();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int a, t0, t1, t2, c1;

    // Reset state
    repeat (3) @(posedge aclk);
    #1;
    check("rst_out_tvalid", 128'(axis_out_tvalid), 128'd0);
    check("rst_in_tready", 128'(axis_in_tready), 128'd0);
    check("rst_dec_ready", 128'(dec_ready), 128'd0);
    check("rst_out_tdata", 128'(axis_out_tdata), 128'd0);
    check("rst_out_tdest", 128'(axis_out_tdest), 128'd0);
    aresetn = 1'b1;
    tick();
    check("idle_dec_ready", 128'(dec_ready), 128'd1);
    check("idle_in_tready", 128'(axis_in_tready), 128'd0);

    // Basic 3-beat packet, 1-cycle latency, full throughput
    send_dec(1'b0, 5'h03, a);
    send_beat(64'h1111_2222_3333_4444, 4'h2, 8'hFF, 1'b0, t0);
    check("lat_out_tvalid", 128'(axis_out_tvalid), 128'd1);
    check("lat_out_tdata", 128'(axis_out_tdata), 128'h1111_2222_3333_4444);
    check("lat_out_tdest", 128'(axis_out_tdest), 128'h03);
    send_beat(64'hAAAA_BBBB_CCCC_DDDD, 4'h2, 8'h0F, 1'b0, t1);
    send_beat(64'h0123_4567_89AB_CDEF, 4'h2, 8'h01, 1'b1, t2);
    check("basic_throughput", 128'(t2 - t0), 128'd2);
    exp_q.push_back(pk(64'h1111_2222_3333_4444, 1'b0, 4'h2, 5'h03, 8'hFF, 1'b0));
    exp_q.push_back(pk(64'hAAAA_BBBB_CCCC_DDDD, 1'b0, 4'h2, 5'h03, 8'h0F, 1'b0));
    exp_q.push_back(pk(64'h0123_4567_89AB_CDEF, 1'b0, 4'h2, 5'h03, 8'h01, 1'b1));
    drain("basic");

    // Drop flag set; tid change mid-packet is ignored
    send_dec(1'b1, 5'h10, a);
    send_beat(64'hDEAD_BEEF_0000_0001, 4'h7, 8'hFF, 1'b0, t0);
    send_beat(64'hDEAD_BEEF_0000_0002, 4'h9, 8'h3F, 1'b1, t1);
    exp_q.push_back(pk(64'hDEAD_BEEF_0000_0001, 1'b1, 4'h7, 5'h10, 8'hFF, 1'b0));
    exp_q.push_back(pk(64'hDEAD_BEEF_0000_0002, 1'b1, 4'h7, 5'h10, 8'h3F, 1'b1));
    drain("drop");

    // Backpressure: two beats buffered, then input stalls with stable output
    send_dec(1'b0, 5'h05, a);
    axis_out_tready = 1'b0;
    send_beat(64'h0000_0000_0000_00B0, 4'h4, 8'hFF, 1'b0, t0);
    check("bp_ready_after_1", 128'(axis_in_tready), 128'd1);
    send_beat(64'h0000_0000_0000_00B1, 4'h5, 8'hFF, 1'b0, t1);
    check("bp_ready_drop", 128'(axis_in_tready), 128'd0);
    axis_in_tdata = 64'h0000_0000_0000_00B2;
    axis_in_tvalid = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      check($sformatf("bp_hold_valid%0d", i), 128'(axis_out_tvalid), 128'd1);
      check($sformatf("bp_hold_data%0d", i), 128'(axis_out_tdata), 128'hB0);
      check($sformatf("bp_hold_tid%0d", i), 128'(axis_out_tid), 128'h4);
      check($sformatf("bp_hold_ready%0d", i), 128'(axis_in_tready), 128'd0);
    end
    axis_out_tready = 1'b1;
    send_beat(64'h0000_0000_0000_00B2, 4'h6, 8'hFF, 1'b0, t0);
    send_beat(64'h0000_0000_0000_00B3, 4'h7, 8'h80, 1'b1, t1);
    exp_q.push_back(pk(64'hB0, 1'b0, 4'h4, 5'h05, 8'hFF, 1'b0));
    exp_q.push_back(pk(64'hB1, 1'b0, 4'h4, 5'h05, 8'hFF, 1'b0));
    exp_q.push_back(pk(64'hB2, 1'b0, 4'h4, 5'h05, 8'hFF, 1'b0));
    exp_q.push_back(pk(64'hB3, 1'b0, 4'h4, 5'h05, 8'h80, 1'b1));
    drain("bp");

    // Back-to-back single-beat packets
    send_dec(1'b0, 5'h01, a);
    send_beat(64'h5555_0000_0000_0001, 4'h1, 8'hFF, 1'b1, t1);
    send_dec(1'b1, 5'h1E, c1);
    send_beat(64'h5555_0000_0000_0002, 4'hC, 8'h0F, 1'b1, t2);
    check("b2b_dec_cycle", 128'(c1 - t1), 128'd1);
    check("b2b_input_gap", 128'(t2 - t1), 128'd2);
    exp_q.push_back(pk(64'h5555_0000_0000_0001, 1'b0, 4'h1, 5'h01, 8'hFF, 1'b1));
    exp_q.push_back(pk(64'h5555_0000_0000_0002, 1'b1, 4'hC, 5'h1E, 8'h0F, 1'b1));
    drain("b2b");

    // Decision with no data is held
    send_dec(1'b0, 5'h07, a);
    repeat (5) tick();
    check("held_in_tready", 128'(axis_in_tready), 128'd1);
    check("held_dec_ready", 128'(dec_ready), 128'd0);
    send_beat(64'h7777_7777_7777_7777, 4'h3, 8'hFF, 1'b1, t0);
    exp_q.push_back(pk(64'h7777_7777_7777_7777, 1'b0, 4'h3, 5'h07, 8'hFF, 1'b1));
    drain("held");

    // Data with no decision is not accepted
    axis_in_tdata = 64'h9999_0000_9999_0000;
    axis_in_tid = 4'hA;
    axis_in_tkeep = 8'hF0;
    axis_in_tlast = 1'b1;
    axis_in_tvalid = 1'b1;
    repeat (4) tick();
    check("nodec_in_tready", 128'(axis_in_tready), 128'd0);
    check("nodec_out_tvalid", 128'(axis_out_tvalid), 128'd0);
    check("nodec_no_output", 128'(obs_q.size()), 128'd0);
    send_dec(1'b1, 5'h12, a);
    send_beat(64'h9999_0000_9999_0000, 4'hA, 8'hF0, 1'b1, t0);
    exp_q.push_back(pk(64'h9999_0000_9999_0000, 1'b1, 4'hA, 5'h12, 8'hF0, 1'b1));
    drain("nodec");

    // Reset mid-packet, then a fresh 1-beat packet with tkeep=0
    send_dec(1'b0, 5'h0A, a);
    axis_out_tready = 1'b0;
    send_beat(64'hCAFE_0000_0000_0001, 4'h3, 8'hFF, 1'b0, t0);
    check("prerst_out_tvalid", 128'(axis_out_tvalid), 128'd1);
    axis_in_tdata = 64'hCAFE_0000_0000_0002;
    axis_in_tvalid = 1'b1;
    #2;
    aresetn = 1'b0;
    #1;
    check("midrst_out_tvalid", 128'(axis_out_tvalid), 128'd0);
    check("midrst_in_tready", 128'(axis_in_tready), 128'd0);
    check("midrst_dec_ready", 128'(dec_ready), 128'd0);
    axis_in_tvalid = 1'b0;
    obs_q.delete();
    exp_q.delete();
    tick();
    aresetn = 1'b1;
    axis_out_tready = 1'b1;
    tick();
    check("postrst_dec_ready", 128'(dec_ready), 128'd1);
    send_dec(1'b1, 5'h0C, a);
    send_beat(64'hFEED_FACE_0000_0003, 4'h5, 8'h00, 1'b1, t0);
    exp_q.push_back(pk(64'hFEED_FACE_0000_0003, 1'b1, 4'h5, 5'h0C, 8'h00, 1'b1));
    drain("postrst");

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
